dram_model: RTL

- Synthesizable DDR3 device-side responder for the DFI command/data interface that dram_control drives.
- Decodes RAS/CAS/WE commands and tracks the open row in each bank.
- Stores write bursts in a small on-chip array and returns read bursts after a fixed CAS latency.
- Used in simulation and on-board loopback in place of the ddio/pll physical path, so controller and test-pattern logic can be verified without a DRAM part.

---
 rtl/dram_pkg.sv | 43 ++++
 rtl/dram_model_if.sv | 32 +++
 rtl/dram_burst_pipe.sv | 86 ++++++++
 rtl/dram_model.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// dram_pkg: shared types and constants for the DDR3 device-side responder.
// Holds the DFI command enum (built from {rasn,casn,wen}), the burst length,
// the sticky error bit positions and the default CAS/CAS-write latencies that
// the controller side uses as well.
package dram_pkg;

  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_NOP = 3'b111
  } dram_cmd_e;

  localparam int BURST_LEN   = 4;
  localparam int DEFAULT_CL  = 5;
  localparam int DEFAULT_CWL = 4;

  localparam int ERR_BITS          = 6;
  localparam int ERR_CLOSED        = 0;
  localparam int ERR_ACT_OPEN      = 1;
  localparam int ERR_REF_OPEN      = 2;
  localparam int ERR_COLLIDE       = 3;
  localparam int ERR_WR_MISSING    = 4;
  localparam int ERR_WR_UNEXPECTED = 5;

  // Code 110 has no meaning on this device and is treated as a NOP.
  function automatic dram_cmd_e decode_cmd(input logic rasn, input logic casn,
                                           input logic wen);
    case ({rasn, casn, wen})
      3'b000:  return CMD_MRS;
      3'b001:  return CMD_REF;
      3'b010:  return CMD_PRE;
      3'b011:  return CMD_ACT;
      3'b100:  return CMD_WR;
      3'b101:  return CMD_RD;
      default: return CMD_NOP;
    endcase
  endfunction

endpackage

// File: rtl/dram_model_if.sv
// dram_model_if: DFI command/data bundle between dram_control and the
// dram_model responder.
//   addr/bank          command address and bank select
//   rasn/casn/wen/csn  active-low command strobes and chip select
//   cke/rstn           clock enable, active-low device reset
//   wdata/wmask        write beat and "controller is driving data" flag
//   rdata/rvalid       read beat returned by the device
// master = controller side, slave = device side.
interface dram_model_if;
  logic [14:0] addr;
  logic [2:0]  bank;
  logic        rasn;
  logic        casn;
  logic        wen;
  logic        csn;
  logic        cke;
  logic        rstn;
  logic [31:0] wdata;
  logic        wmask;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (
    output addr, bank, rasn, casn, wen, csn, cke, rstn, wdata, wmask,
    input  rdata, rvalid
  );

  modport slave (
    input  addr, bank, rasn, casn, wen, csn, cke, rstn, wdata, wmask,
    output rdata, rvalid
  );
endinterface

// File: rtl/dram_burst_pipe.sv
// dram_burst_pipe: delay line with beat expansion. A launch entered in cycle t
// produces beats 0..3 in cycles t+DELAY .. t+DELAY+3 (combinational outputs).
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   clear_i          synchronous flush of every stage
//   launch_i         start a burst this cycle
//   payload_i        address fields carried along with the burst
//   beat_valid_o     a beat is due this cycle
//   payload_o        address fields of the burst owning this beat
//   beat_o           beat number 0..3
//   overlap_o        a new launch lands on a burst still being emitted
module dram_burst_pipe
  import dram_pkg::*;
#(
  parameter int DEPTH = 9,
  parameter int DELAY = 4,
  parameter int PW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          launch_i,
  input  logic [PW-1:0] payload_i,
  output logic          beat_valid_o,
  output logic [PW-1:0] payload_o,
  output logic [1:0]    beat_o,
  output logic          overlap_o
);

  typedef struct packed {
    logic          valid;
    logic [PW-1:0] payload;
  } stage_t;

  stage_t [DEPTH-1:0] stage_q, stage_d;

  always_comb begin
    stage_d = stage_q;
    stage_d[0].valid   = launch_i;
    stage_d[0].payload = payload_i;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    if (clear_i) begin
      stage_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // Stage DELAY-1+k holds the burst that owes beat k this cycle. Scanning
  // from the oldest beat down lets the newest burst win any overlap.
  always_comb begin
    beat_valid_o = 1'b0;
    payload_o    = '0;
    beat_o       = '0;
    for (int k = BURST_LEN - 1; k >= 0; k--) begin
      if (stage_q[DELAY-1+k].valid) begin
        beat_valid_o = 1'b1;
        payload_o    = stage_q[DELAY-1+k].payload;
        beat_o       = 2'(k);
      end
    end
  end

  // Bursts launched fewer than BURST_LEN clocks apart share beat slots.
  always_comb begin
    overlap_o = 1'b0;
    for (int i = 0; i < BURST_LEN - 1; i++) begin
      if (stage_q[i].valid) begin
        overlap_o = launch_i;
      end
    end
  end

  // Stages past the last tap only exist to keep the line at its full depth.
  logic unused_tail;
  assign unused_tail = ^stage_q[DEPTH-1:DELAY+BURST_LEN-1];

endmodule

// File: rtl/dram_model.sv
// dram_model: synthesizable DDR3 device-side responder for the DFI bus.
// Tracks open rows per bank, stores write bursts in an on-chip array and
// returns read bursts CL clocks after RD.
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   dfi          DFI command/data bundle (slave side)
//   err          sticky errors, bit positions from dram_pkg
//   open_banks   per-bank open flags
module dram_model
  import dram_pkg::*;
#(
  parameter int CL       = DEFAULT_CL,
  parameter int CWL      = DEFAULT_CWL,
  parameter int MEM_BITS = 10,
  parameter int ROW_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  dram_model_if.slave         dfi,
  output logic [ERR_BITS-1:0] err,
  output logic [7:0]          open_banks
);

  localparam int PIPE_DEPTH = ((CL > CWL) ? CL : CWL) + BURST_LEN;
  localparam int PW         = 3 + ROW_BITS + 7;

  logic [7:0]                open_q, open_d;
  logic [7:0][ROW_BITS-1:0]  row_q, row_d;
  logic [ERR_BITS-1:0]       err_q, err_d;
  logic                      rvalid_q;
  logic [31:0]               rdata_q;
  logic [31:0]               mem_q [2**MEM_BITS];

  dram_cmd_e     cmd;
  logic [PW-1:0] cmd_payload;
  logic          rd_valid, wr_valid, rd_overlap, wr_overlap, wr_en;
  logic [PW-1:0] rd_payload, wr_payload;
  logic [1:0]    rd_beat, wr_beat;
  logic [MEM_BITS-1:0] rd_idx, wr_idx;

  always_comb begin
    cmd = CMD_NOP;
    if (dfi.cke && !dfi.csn && dfi.rstn) begin
      cmd = decode_cmd(dfi.rasn, dfi.casn, dfi.wen);
    end
  end

  // RD/WR on a closed bank still launch with whatever row was last stored.
  assign cmd_payload = {dfi.bank, row_q[dfi.bank], dfi.addr[9:3]};

  // The read pipe taps one clock early because the array read is registered.
  dram_burst_pipe #(.DEPTH(PIPE_DEPTH), .DELAY(CL - 1), .PW(PW)) u_rd_pipe (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (!dfi.rstn),
    .launch_i     (cmd == CMD_RD),
    .payload_i    (cmd_payload),
    .beat_valid_o (rd_valid),
    .payload_o    (rd_payload),
    .beat_o       (rd_beat),
    .overlap_o    (rd_overlap)
  );

  dram_burst_pipe #(.DEPTH(PIPE_DEPTH), .DELAY(CWL), .PW(PW)) u_wr_pipe (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (!dfi.rstn),
    .launch_i     (cmd == CMD_WR),
    .payload_i    (cmd_payload),
    .beat_valid_o (wr_valid),
    .payload_o    (wr_payload),
    .beat_o       (wr_beat),
    .overlap_o    (wr_overlap)
  );

  // Indices wider than the store are truncated on purpose, so banks alias.
  assign rd_idx = MEM_BITS'({rd_payload, rd_beat});
  assign wr_idx = MEM_BITS'({wr_payload, wr_beat});
  assign wr_en  = wr_valid && dfi.wmask;

  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    err_d  = err_q;
    if (!dfi.rstn) begin
      open_d = '0;
      row_d  = '0;
    end else begin
      case (cmd)
        CMD_ACT: begin
          if (open_q[dfi.bank]) err_d[ERR_ACT_OPEN] = 1'b1;
          open_d[dfi.bank] = 1'b1;
          row_d[dfi.bank]  = dfi.addr[ROW_BITS-1:0];
        end
        CMD_PRE: begin
          if (dfi.addr[10]) open_d = '0;
          else              open_d[dfi.bank] = 1'b0;
        end
        CMD_RD, CMD_WR: begin
          if (!open_q[dfi.bank]) err_d[ERR_CLOSED] = 1'b1;
        end
        CMD_REF: begin
          if (|open_q) err_d[ERR_REF_OPEN] = 1'b1;
        end
        default: ;
      endcase
      // rvalid_q marks the read beat on the bus this cycle, which is the
      // same cycle the write pipe says its beat is due.
      if (rd_overlap || wr_overlap || (rvalid_q && wr_valid)) begin
        err_d[ERR_COLLIDE] = 1'b1;
      end
      if (wr_valid && !dfi.wmask) err_d[ERR_WR_MISSING] = 1'b1;
      if (!wr_valid && dfi.wmask) err_d[ERR_WR_UNEXPECTED] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      open_q <= '0;
      row_q  <= '0;
      err_q  <= '0;
    end else begin
      open_q <= open_d;
      row_q  <= row_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= dfi.wdata;
    end
  end

  // A write landing on the same edge as the array read is forwarded so that
  // a write one clock ahead of a read beat is already visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (!dfi.rstn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd_valid;
      if (!rd_valid)                       rdata_q <= '0;
      else if (wr_en && (wr_idx == rd_idx)) rdata_q <= dfi.wdata;
      else                                 rdata_q <= mem_q[rd_idx];
    end
  end

  assign dfi.rdata  = rdata_q;
  assign dfi.rvalid = rvalid_q;
  assign err        = err_q;
  assign open_banks = open_q;

  // Only the low row bits reach the store index; column bits [2:0] select
  // the beat within a burst and are implied by the beat counter.
  logic unused_addr;
  assign unused_addr = ^{dfi.addr[14:ROW_BITS], dfi.addr[2:0]};

endmodule
